// File: rtl/proj_switch_pkg.sv
// Shared types and constants for the project switch controller.
// FSM encoding, status word layout and register offsets.
package proj_switch_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_ISOLATE = 2'd1,
    ST_RESET   = 2'd2,
    ST_SETTLE  = 2'd3
  } state_t;

  localparam int STAT_PEND_LSB  = 0;
  localparam int STAT_STATE_LSB = 12;
  localparam int STAT_BUSY_BIT  = 14;
  localparam int STAT_ERR_BIT   = 15;

  localparam logic [31:0] BASE_ADDR  = 32'h3000_0000;
  localparam logic [31:0] OFF_SEL    = 32'h0;
  localparam logic [31:0] OFF_STATUS = 32'h4;
  localparam logic [31:0] OFF_AUTO   = 32'h8;

  function automatic logic [31:0] status_word(
    input logic       err,
    input logic       busy,
    input state_t     st,
    input logic [7:0] pend
  );
    logic [31:0] w;
    w = '0;
    w[STAT_ERR_BIT] = err;
    w[STAT_BUSY_BIT] = busy;
    w[STAT_STATE_LSB +: 2] = st;
    w[STAT_PEND_LSB +: 8] = pend;
    return w;
  endfunction

endpackage

// File: rtl/project_switch_ctrl_if.sv
// Wishbone slave bundle for the project switch controller.
// Signal names follow the harness wbs_* naming.
interface project_switch_ctrl_if;

  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i,
    output wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i,
    input  wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

endinterface

// File: rtl/switch_wb_regs.sv
// Wishbone decode, single-pulse ack and read mux.
// Effective select writes stall until the FSM is back in RUN.
module switch_wb_regs
  import proj_switch_pkg::*;
#(
  parameter logic [31:0] ADDR_SEL    = BASE_ADDR + OFF_SEL,
  parameter logic [31:0] ADDR_STATUS = BASE_ADDR + OFF_STATUS
`ifdef PROJ_AUTO_CYCLE_EN
  ,
  parameter logic [31:0] ADDR_AUTO   = BASE_ADDR + OFF_AUTO
`endif
) (
  input  logic        clk,
  input  logic        reset,
  project_switch_ctrl_if.slave wb,
  input  logic        run,
  input  logic        busy,
  input  logic        err,
  input  state_t      state,
  input  logic [7:0]  active_project,
  input  logic [7:0]  pending,
  output logic        sel_wr,
  output logic [7:0]  sel_data,
  output logic        clr_err
`ifdef PROJ_AUTO_CYCLE_EN
  ,
  output logic [31:0] period
`endif
);

  logic        valid;
  logic        hit_sel;
  logic        hit_stat;
  logic        hit_any;
  logic        stall;
  logic        accept;
  logic [31:0] rdata;

  assign valid    = wb.wbs_cyc_i & wb.wbs_stb_i & ~wb.wbs_ack_o;
  assign hit_sel  = wb.wbs_adr_i == ADDR_SEL;
  assign hit_stat = wb.wbs_adr_i == ADDR_STATUS;

`ifdef PROJ_AUTO_CYCLE_EN
  logic hit_auto;
  assign hit_auto = wb.wbs_adr_i == ADDR_AUTO;
  assign hit_any  = hit_sel | hit_stat | hit_auto;
`else
  logic unused_bits;
  assign unused_bits = ^{wb.wbs_sel_i[3:1], wb.wbs_dat_i[31:8]};
  assign hit_any  = hit_sel | hit_stat;
`endif

  assign stall = hit_sel & wb.wbs_we_i & wb.wbs_sel_i[0] & ~run;
  assign accept = valid & hit_any & ~stall;

  assign sel_wr   = accept & wb.wbs_we_i & hit_sel & wb.wbs_sel_i[0];
  assign sel_data = wb.wbs_dat_i[7:0];
  assign clr_err  = accept & wb.wbs_we_i & hit_stat
                  & wb.wbs_sel_i[0] & wb.wbs_dat_i[0];

  // Read data selection by decoded register.
  always_comb begin
    rdata = '0;
    unique case (1'b1)
      hit_sel:  rdata = {24'b0, active_project};
      hit_stat: rdata = status_word(err, busy, state, pending);
`ifdef PROJ_AUTO_CYCLE_EN
      hit_auto: rdata = period;
`endif
      default:  rdata = '0;
    endcase
  end

  // Registered ack pulse and read data, zero outside an ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb.wbs_ack_o <= 1'b0;
      wb.wbs_dat_o <= '0;
    end else begin
      wb.wbs_ack_o <= accept;
      wb.wbs_dat_o <= (accept & ~wb.wbs_we_i) ? rdata : '0;
    end
  end

`ifdef PROJ_AUTO_CYCLE_EN
  // Auto-cycle period register, byte-enabled writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      period <= '0;
    end else if (accept & wb.wbs_we_i & hit_auto) begin
      for (int b = 0; b < 4; b++) begin
        if (wb.wbs_sel_i[b]) period[b*8 +: 8] <= wb.wbs_dat_i[b*8 +: 8];
      end
    end
  end
`endif

endmodule

// File: rtl/project_switch_ctrl.sv
// Active-project owner and safe switch sequencer (isolate/reset/settle).
// Optional auto-cycling built when PROJ_AUTO_CYCLE_EN is defined.
module project_switch_ctrl
  import proj_switch_pkg::*;
#(
  parameter logic [31:0] ADDR_SEL      = BASE_ADDR + OFF_SEL,
  parameter logic [31:0] ADDR_STATUS   = BASE_ADDR + OFF_STATUS,
`ifdef PROJ_AUTO_CYCLE_EN
  parameter logic [31:0] ADDR_AUTO     = BASE_ADDR + OFF_AUTO,
`endif
  parameter int          NUM_PROJECTS  = 5,
  parameter int          RESET_CYCLES  = 16,
  parameter int          SETTLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  project_switch_ctrl_if.slave    wbs,
  output logic [7:0]              active_project,
  output logic                    io_isolate,
  output logic [NUM_PROJECTS-1:0] project_reset,
  output logic                    busy
);

  localparam int         CNT_W = 16;
  localparam logic [7:0] NUM_P = 8'(NUM_PROJECTS);

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       pending;
  logic             err;
  logic             run;
  logic             sel_wr;
  logic [7:0]       sel_data;
  logic             clr_err;
  logic             host_go;
  logic             host_bad;
  logic             auto_go;

  assign run      = state == ST_RUN;
  assign host_go  = sel_wr & (sel_data < NUM_P)
                  & (sel_data != active_project);
  assign host_bad = sel_wr & (sel_data >= NUM_P);

`ifdef PROJ_AUTO_CYCLE_EN
  logic [31:0] period;
  logic [31:0] idle;
  logic [7:0]  next_proj;

  assign next_proj = (active_project + 8'd1 == NUM_P) ?
                     8'd0 : active_project + 8'd1;
  assign auto_go = run & (period != '0)
                 & (idle == period - 32'd1) & ~sel_wr;

  // Idle counter runs only in RUN with a nonzero period.
  always_ff @(posedge clk) begin
    if (reset) begin
      idle <= '0;
    end else if (!run || sel_wr || auto_go || period == '0) begin
      idle <= '0;
    end else begin
      idle <= idle + 32'd1;
    end
  end
`else
  assign auto_go = 1'b0;
`endif

  switch_wb_regs #(
    .ADDR_SEL    (ADDR_SEL),
    .ADDR_STATUS (ADDR_STATUS)
`ifdef PROJ_AUTO_CYCLE_EN
    ,
    .ADDR_AUTO   (ADDR_AUTO)
`endif
  ) u_regs (
    .clk            (clk),
    .reset          (reset),
    .wb             (wbs),
    .run            (run),
    .busy           (busy),
    .err            (err),
    .state          (state),
    .active_project (active_project),
    .pending        (pending),
    .sel_wr         (sel_wr),
    .sel_data       (sel_data),
    .clr_err        (clr_err)
`ifdef PROJ_AUTO_CYCLE_EN
    ,
    .period         (period)
`endif
  );

  // State register; reset restarts the reset/settle sequence.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_RESET;
    else       state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_RUN:     if (host_go || auto_go) state_nx = ST_ISOLATE;
      ST_ISOLATE: state_nx = ST_RESET;
      ST_RESET:   if (cnt == '0) state_nx = ST_SETTLE;
      ST_SETTLE:  if (cnt == '0) state_nx = ST_RUN;
      default:    state_nx = state;
    endcase
  end

  // Counter, project registers and sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt            <= CNT_W'(RESET_CYCLES - 1);
      active_project <= '0;
      pending        <= '0;
      err            <= 1'b0;
    end else begin
      unique case (state)
        ST_RUN: begin
          if (host_go)      pending <= sel_data;
`ifdef PROJ_AUTO_CYCLE_EN
          else if (auto_go) pending <= next_proj;
`endif
        end
        ST_ISOLATE: begin
          cnt            <= CNT_W'(RESET_CYCLES - 1);
          active_project <= pending;
        end
        ST_RESET: begin
          if (cnt == '0) cnt <= CNT_W'(SETTLE_CYCLES - 1);
          else           cnt <= cnt - CNT_W'(1);
        end
        ST_SETTLE: begin
          if (cnt != '0) cnt <= cnt - CNT_W'(1);
        end
        default: ;
      endcase
      if (clr_err)       err <= 1'b0;
      else if (host_bad) err <= 1'b1;
    end
  end

  // Pad isolation and per-project reset from the current state.
  always_comb begin
    busy          = ~run;
    io_isolate    = ~run;
    project_reset = '1;
    if (state == ST_RUN || state == ST_SETTLE) begin
      for (int i = 0; i < NUM_PROJECTS; i++) begin
        project_reset[i] = active_project != 8'(i);
      end
    end
  end

endmodule

// File: tb/tb_project_switch_ctrl.sv
// Directed bench for project_switch_ctrl.
// Auto-cycle checks compile in with PROJ_AUTO_CYCLE_EN.
module tb_project_switch_ctrl;

  localparam logic [31:0] A_SEL  = 32'h3000_0000;
  localparam logic [31:0] A_STAT = 32'h3000_0004;
  localparam logic [31:0] A_AUTO = 32'h3000_0008;
  localparam logic [31:0] A_BAD  = 32'h3000_0010;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] active_project;
  logic       io_isolate;
  logic [4:0] project_reset;
  logic       busy;
  logic       prev_ack = 1'b0;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  project_switch_ctrl_if wbs ();

  project_switch_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .wbs            (wbs),
    .active_project (active_project),
    .io_isolate     (io_isolate),
    .project_reset  (project_reset),
    .busy           (busy)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic wb_cycle(input logic we, input logic [31:0] adr,
                          input logic [31:0] dat, input int limit,
                          output logic ok, output logic [31:0] rd,
                          output int waited);
    wbs.wbs_cyc_i = 1'b1;
    wbs.wbs_stb_i = 1'b1;
    wbs.wbs_we_i  = we;
    wbs.wbs_sel_i = 4'hf;
    wbs.wbs_adr_i = adr;
    wbs.wbs_dat_i = dat;
    ok = 1'b0;
    rd = '0;
    waited = 0;
    while (!ok && waited < limit) begin
      @(posedge clk); #1;
      waited++;
      if (wbs.wbs_ack_o) begin
        ok = 1'b1;
        rd = wbs.wbs_dat_o;
      end
    end
    wbs.wbs_cyc_i = 1'b0;
    wbs.wbs_stb_i = 1'b0;
    wbs.wbs_we_i  = 1'b0;
  endtask

  task automatic count_iso(output int n);
    n = 0;
    while (io_isolate && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic count_busy(output int n, output logic [7:0] act1);
    n = 0;
    act1 = '0;
    while (busy && n < 100) begin
      if (n == 1) act1 = active_project;
      n++;
      @(posedge clk); #1;
    end
  endtask

  // Ack must never be high on two consecutive cycles.
  always @(posedge clk) begin
    #1;
    if (wbs.wbs_ack_o) check("ack_single", 32'(prev_ack), 32'd0);
    prev_ack = wbs.wbs_ack_o;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic        ok;
    logic [31:0] rd;
    logic [7:0]  act1;
    int          w;
    int          n;
    int          acks;

    wbs.wbs_cyc_i = 1'b0;
    wbs.wbs_stb_i = 1'b0;
    wbs.wbs_we_i  = 1'b0;
    wbs.wbs_sel_i = 4'h0;
    wbs.wbs_adr_i = '0;
    wbs.wbs_dat_i = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_act", 32'(active_project), 32'd0);
    check("rst_iso", 32'(io_isolate), 32'd1);
    check("rst_prst", 32'(project_reset), 32'h1f);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_ack", 32'(wbs.wbs_ack_o), 32'd0);
    check("rst_dat", wbs.wbs_dat_o, 32'd0);
    reset = 1'b0;

    count_iso(n);
    check("boot_iso_len", 32'(n), 32'd20);
    check("boot_act", 32'(active_project), 32'd0);
    check("boot_prst", 32'(project_reset), 32'h1e);
    check("boot_busy", 32'(busy), 32'd0);

    wb_cycle(1'b1, A_SEL, 32'd3, 50, ok, rd, w);
    check("sel3_ack", 32'(ok), 32'd1);
    check("sel3_lat", 32'(w), 32'd1);
    check("sel3_iso_act", 32'(active_project), 32'd0);
    count_busy(n, act1);
    check("sel3_busy_len", 32'(n), 32'd21);
    check("sel3_act_rst", 32'(act1), 32'd3);
    check("sel3_prst", 32'(project_reset), 32'h17);
    check("sel3_iso", 32'(io_isolate), 32'd0);
    wb_cycle(1'b0, A_SEL, 32'd0, 50, ok, rd, w);
    check("rd_sel", rd, 32'd3);

    wb_cycle(1'b1, A_SEL, 32'd7, 50, ok, rd, w);
    check("sel7_ack", 32'(ok), 32'd1);
    check("sel7_busy", 32'(busy), 32'd0);
    check("sel7_act", 32'(active_project), 32'd3);
    wb_cycle(1'b0, A_STAT, 32'd0, 50, ok, rd, w);
    check("stat_err", rd, 32'h0000_8003);
    wb_cycle(1'b1, A_STAT, 32'd1, 50, ok, rd, w);
    check("clr_ack", 32'(ok), 32'd1);
    wb_cycle(1'b0, A_STAT, 32'd0, 50, ok, rd, w);
    check("stat_clr", rd, 32'h0000_0003);

    wb_cycle(1'b1, A_SEL, 32'd3, 50, ok, rd, w);
    check("same_ack", 32'(ok), 32'd1);
    check("same_busy", 32'(busy), 32'd0);

    wb_cycle(1'b1, A_BAD, 32'd1, 5, ok, rd, w);
    check("bad_noack", 32'(ok), 32'd0);
    check("bad_dat", wbs.wbs_dat_o, 32'd0);
`ifndef PROJ_AUTO_CYCLE_EN
    wb_cycle(1'b0, A_AUTO, 32'd0, 5, ok, rd, w);
    check("auto_noack", 32'(ok), 32'd0);
`endif

    wb_cycle(1'b1, A_SEL, 32'd1, 50, ok, rd, w);
    check("sel1_ack", 32'(ok), 32'd1);
    wb_cycle(1'b1, A_SEL, 32'd2, 60, ok, rd, w);
    check("stall_ack", 32'(ok), 32'd1);
    check("stall_wait", 32'(w), 32'd22);
    check("stall_busy", 32'(busy), 32'd1);
    check("stall_act", 32'(active_project), 32'd1);
    count_busy(n, act1);
    check("sel2_busy_len", 32'(n), 32'd21);
    check("sel2_act", 32'(active_project), 32'd2);
    check("sel2_prst", 32'(project_reset), 32'h1b);

    wbs.wbs_cyc_i = 1'b1;
    wbs.wbs_stb_i = 1'b1;
    wbs.wbs_we_i  = 1'b0;
    wbs.wbs_adr_i = A_SEL;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (wbs.wbs_ack_o) acks++;
    end
    wbs.wbs_cyc_i = 1'b0;
    wbs.wbs_stb_i = 1'b0;
    check("b2b_acks", 32'(acks), 32'd3);

    wb_cycle(1'b1, A_SEL, 32'd4, 50, ok, rd, w);
    check("sel4_ack", 32'(ok), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("mid_act", 32'(active_project), 32'd4);
    check("mid_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_act", 32'(active_project), 32'd0);
    check("abort_prst", 32'(project_reset), 32'h1f);
    check("abort_iso", 32'(io_isolate), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    count_iso(n);
    check("reboot_iso_len", 32'(n), 32'd20);
    wb_cycle(1'b0, A_STAT, 32'd0, 50, ok, rd, w);
    check("reboot_stat", rd, 32'd0);
    check("reboot_prst", 32'(project_reset), 32'h1e);

`ifdef PROJ_AUTO_CYCLE_EN
    wb_cycle(1'b1, A_SEL, 32'd4, 50, ok, rd, w);
    count_busy(n, act1);
    check("auto_pre_act", 32'(active_project), 32'd4);
    wb_cycle(1'b1, A_AUTO, 32'd100, 50, ok, rd, w);
    check("auto_wr_ack", 32'(ok), 32'd1);
    n = 0;
    while (!busy && n < 300) begin
      n++;
      @(posedge clk); #1;
    end
    check("auto_idle_len", 32'(n), 32'd100);
    count_busy(n, act1);
    check("auto_busy_len", 32'(n), 32'd21);
    check("auto_wrap_act", 32'(active_project), 32'd0);
    wb_cycle(1'b0, A_AUTO, 32'd0, 50, ok, rd, w);
    check("auto_rd", rd, 32'd100);
    wb_cycle(1'b1, A_AUTO, 32'd0, 50, ok, rd, w);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (busy) n++;
    end
    check("auto_off", 32'(n), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/project_switch_ctrl.md
Name: project_switch_ctrl

Overview:
Wishbone-configured controller that owns the active-project register of the multi-project harness and sequences every project switch safely. On a select write it isolates the IO pads, holds the project in reset for a fixed time, lets the pads settle, and only then hands the IOs to the new project. Idle projects are held in reset. The harness IO mux consumes active_project, io_isolate and project_reset.

Parameters:
ADDR_SEL, 32'h30000000, project-select register (R/W)
ADDR_STATUS, 32'h30000004, status register (R); write bit0=1 clears error flag
NUM_PROJECTS, 5, number of selectable projects (1..255)
RESET_CYCLES, 16, cycles the RESET state lasts (>=1)
SETTLE_CYCLES, 4, cycles the SETTLE state lasts (>=1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
wbs_cyc_i  in  1  wishbone cycle
wbs_stb_i  in  1  wishbone strobe
wbs_we_i  in  1  write enable
wbs_sel_i  in  4  byte selects
wbs_adr_i  in  32  address
wbs_dat_i  in  32  write data
wbs_ack_o  out  1  ack, registered single-cycle pulse
wbs_dat_o  out  32  read data, valid with ack, else 0
active_project  out  8  project currently owning the IOs
io_isolate  out  1  1: harness forces io_oeb all-1 and io_out all-0
project_reset  out  NUM_PROJECTS  per-project reset, active-high
busy  out  1  switch sequence in progress

Behaviour:
- valid = cyc & stb. The block acks only ADDR_SEL and ADDR_STATUS (plus ADDR_AUTO when the optional feature is compiled in). Other addresses get no ack and wbs_dat_o stays 0.
- Ack rule: ack is registered and asserts the cycle after an accepted request. It is never high two consecutive cycles: no new acceptance while wbs_ack_o=1.
- FSM states: RUN, ISOLATE, RESET, SETTLE. Encode as a 2-bit state.
- On reset:
  - state=RESET, counter=RESET_CYCLES-1, active_project=0, pending=0, err=0.
  - wbs_ack_o=0, wbs_dat_o=0, io_isolate=1, project_reset all 1, busy=1.
  - After reset, the FSM runs RESET -> SETTLE -> RUN normally.
- Select write (we=1, sel[0]=1, ADDR_SEL) in RUN:
  - If dat[7:0] >= NUM_PROJECTS: no state change, err<=1, ack.
  - If dat[7:0] == active_project: no sequence, ack.
  - Otherwise: pending<=dat[7:0], ack, state<=ISOLATE.
- Select write with sel[0]=0: ack, no effect.
- Select write while busy: stalled. No ack until the FSM returns to RUN; it is then evaluated as above. The master holds the request stable.
- ISOLATE: 1 cycle. Outputs: io_isolate=1; project_reset all 1; active_project unchanged.
- RESET:
  - active_project<=pending on entry.
  - Counter loaded with RESET_CYCLES-1 and counts down; exit to SETTLE when the counter is 0.
  - Outputs: project_reset all 1; io_isolate=1.
- SETTLE:
  - Counter loaded with SETTLE_CYCLES-1; exit to RUN at 0.
  - Outputs: project_reset = all 1 except bit[active_project]=0; io_isolate=1.
- RUN: io_isolate=0; project_reset = ~onehot(active_project).
- Timing: total busy time per switch = 1+RESET_CYCLES+SETTLE_CYCLES cycles (21 with defaults). busy=1 in every non-RUN state.
- Reads (we=0) are served in any state, 1-cycle latency:
  - ADDR_SEL returns {24'b0, active_project}.
  - ADDR_STATUS returns {16'b0, err, busy, state[1:0], 4'b0, pending[7:0]}.
- ADDR_STATUS write: bit0=1 clears err; ack; served in any state. If the same cycle sets err, clear wins over set.
- reset asserted mid-sequence aborts it and restarts the reset behaviour above. pending is lost.

Optional Feature:
Macro PROJ_AUTO_CYCLE_EN.
- Defined:
  - Adds parameter ADDR_AUTO=32'h30000008 (R/W, 32-bit period) and a 32-bit idle counter.
  - Period reset value is 0 (disabled). A nonzero period enables auto-cycling.
  - In RUN, the counter increments each cycle. When it reaches period-1: pending<=(active_project+1) mod NUM_PROJECTS, the counter clears, and the FSM goes to ISOLATE.
  - A host select write in the same cycle takes priority and the counter clears.
  - The counter clears on leaving RUN.
- Undefined: ADDR_AUTO is not decoded (no ack) and no counter logic exists.

Decomposition:
- Package proj_switch_pkg holds:
  - state enum values RUN=0, ISOLATE=1, RESET=2, SETTLE=3;
  - status bit positions;
  - default register offsets (SEL=0x0, STATUS=0x4, AUTO=0x8).
- One natural sub-module: switch_wb_regs, the wishbone decode, ack generator and read mux. The FSM and counter stay in the top module.

Test Plan:
- Release reset -> io_isolate=1 for 1+16+4 total... exactly RESET_CYCLES+SETTLE_CYCLES=20 cycles after reset deasserts, then 0; active_project=0; project_reset=5'b11110.
- Write ADDR_SEL=3 in RUN -> ack next cycle; busy for exactly 21 cycles; active_project=3 from first RESET cycle; final project_reset=5'b10111.
- Write ADDR_SEL=7 -> ack, active_project unchanged, STATUS read bit15=1; write STATUS=1 -> bit15 reads 0.
- Write ADDR_SEL=2 while busy from a prior switch to 1 -> no ack until RUN, then ack and a second 21-cycle sequence ending with active_project=2.
- Assert reset during RESET state of a switch to 4 -> active_project=0 and full reset sequence restarts; back-to-back requests never yield two consecutive ack cycles.
- (PROJ_AUTO_CYCLE_EN) Write ADDR_AUTO=100 with active_project=4 -> after 100 RUN cycles the sequence starts and ends with active_project=0; write ADDR_AUTO=0 -> no further switches.
